// File: rtl/spi_xfer_sequencer_if.sv
// Bus bundle between the SPI transfer sequencer, its requesters and the
// shared SPI master register port.
//   master modport : the sequencer's view (drives grant/done/err/busy and the
//                    master write port, reads req/req_data/m_ss_bar)
//   slave modport  : the environment's view (requesters plus SPI master)
interface spi_xfer_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic                 busy;
  logic                 m_write;
  logic                 m_cs;
  logic [15:0]          m_address;
  logic [31:0]          m_datain;
  logic                 m_ss_bar;

  modport master (
    input  req, req_data, m_ss_bar,
    output grant, done, err, busy, m_write, m_cs, m_address, m_datain
  );

  modport slave (
    output req, req_data, m_ss_bar,
    input  grant, done, err, busy, m_write, m_cs, m_address, m_datain
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Shares one OPB-style SPI master among NUM_REQ requesters. A pending
// request is arbitrated, the master is programmed over its write port
// (disarm, divider config, data byte, arm, kick), m_ss_bar is tracked
// through start and end of the transfer, the master is disarmed again and
// the winner gets a one-cycle done (or err on timeout) pulse.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - spi_xfer_sequencer_if.master: req/req_data/grant/done/err/busy
//            toward the requesters, m_write/m_cs/m_address/m_datain/m_ss_bar
//            toward the SPI master
//
// Build option: define SPI_SEQ_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise arbitration is round-robin.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no owner; arbitrate pending requests
// WR_SPCR0   | write SPCR=0 so the config writes cannot start the master
// WR_NCLK    | write n_clk_cycles
// WR_HIGH    | write clk_hightime
// WR_LOW     | write clk_lowtime
// WR_DATA    | write the latched byte
// WR_ARM     | write SPCR=0x4A
// WR_KICK    | write SPCR=0x4A again; this one starts the transfer
// WAIT_START | wait for m_ss_bar low, bounded by TIMEOUT
// WAIT_END   | wait for m_ss_bar high, bounded by TIMEOUT
// WR_DIS     | write SPCR=0 to disarm the master
// FINISH     | done/err pulse to owner; release grant/busy
module spi_xfer_sequencer #(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] N_CYCLES  = 32'd16,
  parameter logic [31:0] HIGH_TIME = 32'd2,
  parameter logic [31:0] LOW_TIME  = 32'd2,
  parameter int          TIMEOUT   = 1023
) (
  input logic clock,
  input logic reset,
  spi_xfer_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] WR_SPCR0   = 4'd1;
  localparam logic [3:0] WR_NCLK    = 4'd2;
  localparam logic [3:0] WR_HIGH    = 4'd3;
  localparam logic [3:0] WR_LOW     = 4'd4;
  localparam logic [3:0] WR_DATA    = 4'd5;
  localparam logic [3:0] WR_ARM     = 4'd6;
  localparam logic [3:0] WR_KICK    = 4'd7;
  localparam logic [3:0] WAIT_START = 4'd8;
  localparam logic [3:0] WAIT_END   = 4'd9;
  localparam logic [3:0] WR_DIS     = 4'd10;
  localparam logic [3:0] FINISH     = 4'd11;

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [3:0]       state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [7:0]       byte_q;
  logic             abort, abort_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             wr_nx;
  logic [15:0]      addr_nx;
  logic [31:0]      data_nx;

`ifdef SPI_SEQ_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last to overwrite.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Scan offsets from rr_ptr downward so the nearest candidate wins.
  always_comb begin
    int cand;
    cand    = 0;
    win_any = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req[cand]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (state == IDLE && win_any)
      rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    abort_nx = abort;
    cnt_nx   = cnt;
    case (state)
      IDLE:     if (win_any) state_nx = WR_SPCR0;
      WR_SPCR0: state_nx = WR_NCLK;
      WR_NCLK:  state_nx = WR_HIGH;
      WR_HIGH:  state_nx = WR_LOW;
      WR_LOW:   state_nx = WR_DATA;
      WR_DATA:  state_nx = WR_ARM;
      WR_ARM:   state_nx = WR_KICK;
      WR_KICK: begin
        state_nx = WAIT_START;
        cnt_nx   = '0;
      end
      WAIT_START: begin
        if (!bus.m_ss_bar) begin
          state_nx = WAIT_END;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_nx = WR_DIS;
          abort_nx = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_END: begin
        if (bus.m_ss_bar) begin
          state_nx = WR_DIS;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_nx = WR_DIS;
          abort_nx = 1'b1;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WR_DIS: state_nx = FINISH;
      FINISH: begin
        state_nx = IDLE;
        abort_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they register in
  // lockstep with the state they belong to.
  always_comb begin
    wr_nx   = 1'b1;
    addr_nx = 16'h0000;
    data_nx = 32'h0;
    case (state_nx)
      WR_SPCR0: addr_nx = 16'h000C;
      WR_NCLK:  data_nx = N_CYCLES;
      WR_HIGH: begin
        addr_nx = 16'h0004;
        data_nx = HIGH_TIME;
      end
      WR_LOW: begin
        addr_nx = 16'h0008;
        data_nx = LOW_TIME;
      end
      WR_DATA: begin
        addr_nx = 16'h0010;
        data_nx = {24'h0, byte_q};
      end
      WR_ARM, WR_KICK: begin
        addr_nx = 16'h000C;
        data_nx = 32'h0000_004A;
      end
      WR_DIS:   addr_nx = 16'h000C;
      default:  wr_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      byte_q        <= '0;
      abort         <= 1'b0;
      cnt           <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.err       <= '0;
      bus.busy      <= 1'b0;
      bus.m_write   <= 1'b0;
      bus.m_cs      <= 1'b0;
      bus.m_address <= '0;
      bus.m_datain  <= '0;
    end else begin
      state         <= state_nx;
      abort         <= abort_nx;
      cnt           <= cnt_nx;
      bus.m_write   <= wr_nx;
      bus.m_cs      <= wr_nx;
      bus.m_address <= addr_nx;
      bus.m_datain  <= data_nx;
      bus.done      <= '0;
      bus.err       <= '0;
      if (state == IDLE && win_any) begin
        idx       <= win_idx;
        byte_q    <= bus.req_data[8*win_idx +: 8];
        bus.grant <= ONE << win_idx;
        bus.busy  <= 1'b1;
      end else if (state == FINISH) begin
        bus.grant <= '0;
        bus.busy  <= 1'b0;
      end
      if (state == WR_DIS) begin
        if (abort) bus.err  <= ONE << idx;
        else       bus.done <= ONE << idx;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
module tb_spi_xfer_sequencer;
  localparam int          NR = 4;
  localparam int          TO = 15;
  localparam logic [31:0] NC = 32'd16;
  localparam logic [31:0] HT = 32'd2;
  localparam logic [31:0] LT = 32'd2;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rr_model = 0;
  logic [7:0] data_arr [NR];

  spi_xfer_sequencer_if #(.NUM_REQ(NR)) bus ();

  spi_xfer_sequencer #(
    .NUM_REQ(NR), .N_CYCLES(NC), .HIGH_TIME(HT), .LOW_TIME(LT), .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbiter: first asserted request walking from the pointer.
  function automatic int pick(input logic [NR-1:0] r);
`ifdef SPI_SEQ_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (rr_model + k) % NR;
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic chk_write(input string tag, input logic [15:0] a, input logic [31:0] d);
    chk({tag, " m_write"}, 32'(bus.m_write), 32'd1);
    chk({tag, " m_cs"}, 32'(bus.m_cs), 32'd1);
    chk({tag, " m_address"}, 32'(bus.m_address), 32'(a));
    chk({tag, " m_datain"}, bus.m_datain, d);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " m_write"}, 32'(bus.m_write), 32'd0);
    chk({tag, " m_cs"}, 32'(bus.m_cs), 32'd0);
    chk({tag, " m_address"}, 32'(bus.m_address), 32'd0);
    chk({tag, " m_datain"}, bus.m_datain, 32'd0);
  endtask

  task automatic load_data();
    for (int i = 0; i < NR; i++) bus.req_data[8*i +: 8] = data_arr[i];
  endtask

  // One full transaction from the IDLE cycle to the following IDLE cycle.
  // sdly: WAIT_START cycle in which the master drops ss_bar (out of range =
  // never). elen: WAIT_END cycle in which it raises ss_bar again.
  task automatic run_txn(input logic [NR-1:0] rv, input int sdly, input int elen,
                         input bit drop_req, input string tag);
    int         w;
    logic [7:0] b;
    bit         start_ok, end_ok, ok;
    int         nwait;
    w = pick(rv);
    b = data_arr[w];
`ifndef SPI_SEQ_FIXED_PRIO_EN
    rr_model = (w + 1) % NR;
`endif
    bus.req = rv;
    load_data();
    step();
    chk_write({tag, " spcr0"}, 16'h000C, 32'h0);
    chk({tag, " grant"}, 32'(bus.grant), 32'(oh(w)));
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    // Late changes on req/req_data must not affect this transaction.
    bus.req_data = $urandom;
    bus.req      = NR'($urandom);
    bus.req[w]   = ~drop_req;
    step(); chk_write({tag, " nclk"}, 16'h0000, NC);
    step(); chk_write({tag, " high"}, 16'h0004, HT);
    step(); chk_write({tag, " low"}, 16'h0008, LT);
    step(); chk_write({tag, " data"}, 16'h0010, {24'h0, b});
    step(); chk_write({tag, " arm"}, 16'h000C, 32'h4A);
    step(); chk_write({tag, " kick"}, 16'h000C, 32'h4A);
    start_ok = (sdly >= 1) && (sdly <= TO + 1);
    nwait    = start_ok ? sdly : TO + 1;
    for (int j = 1; j <= nwait; j++) begin
      step();
      chk_quiet({tag, " wait_start"});
      if (start_ok && j == sdly) bus.m_ss_bar = 1'b0;
    end
    ok = start_ok;
    if (start_ok) begin
      end_ok = (elen >= 1) && (elen <= TO + 1);
      nwait  = end_ok ? elen : TO + 1;
      for (int k = 1; k <= nwait; k++) begin
        step();
        chk_quiet({tag, " wait_end"});
        if (end_ok && k == elen) bus.m_ss_bar = 1'b1;
      end
      ok = end_ok;
    end
    step();
    chk_write({tag, " dis"}, 16'h000C, 32'h0);
    chk({tag, " done early"}, 32'(bus.done), 32'd0);
    chk({tag, " err early"}, 32'(bus.err), 32'd0);
    bus.m_ss_bar = 1'b1;
    step();
    chk({tag, " done"}, 32'(bus.done), ok ? 32'(oh(w)) : 32'd0);
    chk({tag, " err"}, 32'(bus.err), ok ? 32'd0 : 32'(oh(w)));
    chk({tag, " finish busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " finish grant"}, 32'(bus.grant), 32'(oh(w)));
    chk_quiet({tag, " finish"});
    step();
    chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " idle grant"}, 32'(bus.grant), 32'd0);
    chk({tag, " idle done"}, 32'(bus.done), 32'd0);
    chk({tag, " idle err"}, 32'(bus.err), 32'd0);
    chk_quiet({tag, " idle"});
  endtask

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.m_ss_bar = 1'b1;
    for (int i = 0; i < NR; i++) data_arr[i] = 8'(8'h10 + i);
    #12;
    chk("reset grant", 32'(bus.grant), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk_quiet("reset");
    reset = 1'b0;
    step();
    step();
    chk("idle no req busy", 32'(bus.busy), 32'd0);
    chk_quiet("idle no req");

    // Contention from reset: rotating service order 0,1,2,3,0.
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 3, 4, 1'b0, "contend");

    // Single request with the reference byte.
    data_arr[1] = 8'hA5;
    run_txn(4'b0010, 2, 3, 1'b0, "single");

    // Start timeout, end timeout, then a normal transaction.
    run_txn(4'b0100, 0, 3, 1'b0, "start_to");
    run_txn(4'b1000, 2, 0, 1'b0, "end_to");
    run_txn(4'b0001, 1, 1, 1'b0, "after_to");

    // Boundaries: ss seen on the last allowed wait cycle is not a timeout.
    run_txn(4'b0010, TO + 1, TO + 1, 1'b0, "edge_ok");
    run_txn(4'b0010, TO + 2, 1, 1'b0, "edge_start_to");
    run_txn(4'b0100, 1, TO + 2, 1'b1, "edge_end_to");

    // Reset while in WAIT_END.
    bus.req = 4'b0010;
    load_data();
    step();
    for (int i = 0; i < 7; i++) step();
    step();
    bus.m_ss_bar = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrst grant", 32'(bus.grant), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst err", 32'(bus.err), 32'd0);
    chk_quiet("midrst");
    bus.m_ss_bar = 1'b1;
    bus.req      = '0;
    rr_model     = 0;
    #3;
    reset = 1'b0;
    step();
    run_txn(4'b1001, 2, 2, 1'b0, "post_rst");

    // Randomized transactions against the reference model.
    for (int t = 0; t < 20; t++) begin
      logic [NR-1:0] rv;
      int            sd, el;
      rv = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) data_arr[i] = 8'($urandom);
      sd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO + 1));
      el = ($urandom_range(0, 7) == 0) ? TO + 2 : int'($urandom_range(1, TO + 1));
      run_txn(rv, sd, el, 1'($urandom_range(0, 1)), "rand");
    end

    bus.req = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
